suspend_ack_ctrl: RTL and testbench

// User-side responder for the FPGA suspend handshake: it takes the suspend request

---
 rtl/suspend_ack_if.sv | 28 ++
 rtl/suspend_ack_ctrl.sv | 147 ++++++++++++++
 tb/tb_suspend_ack_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/suspend_ack_if.sv
// Suspend handshake and datapath control bundle between the suspend responder and its neighbours.
// The slave side is the responder; the master side drives sreq/busy and observes the outputs.
interface suspend_ack_if;
  logic sreq;
  logic busy;
  logic quiesce;
  logic sack;
  logic suspended;
  logic drain_timeout;

  modport master (
    output sreq,
    output busy,
    input  quiesce,
    input  sack,
    input  suspended,
    input  drain_timeout
  );

  modport slave (
    input  sreq,
    input  busy,
    output quiesce,
    output sack,
    output suspended,
    output drain_timeout
  );
endinterface

// File: rtl/suspend_ack_ctrl.sv
// Suspend responder: quiesces the RX datapath on sreq, waits for drain/settle, acknowledges,
// and re-enables the datapath after a resume guard interval once sreq is released.
module suspend_ack_ctrl #(
  parameter int CNT_WIDTH     = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESUME_CYCLES = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  suspend_ack_if.slave bus
);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_SETTLE,
    S_ACK,
    S_RESUME
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST  = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RESUME_LAST = CNT_WIDTH'(RESUME_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  state_e               state_q;
  logic                 sync1_q;
  logic                 sync2_q;
  logic [CNT_WIDTH-1:0] drain_cnt_q;
  logic [CNT_WIDTH-1:0] settle_cnt_q;
  logic [CNT_WIDTH-1:0] res_cnt_q;
  logic                 quiesce_q;
  logic                 sack_q;
  logic                 suspended_q;
  logic                 drain_timeout_q;
  logic                 sreq_s;

  // sreq arrives from another clock domain; only the second flop is used by the FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.sreq;
      sync2_q <= sync1_q;
    end
  end

  assign sreq_s = sync2_q;

  // Outputs are registered alongside the state so they change on the transition edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= S_RUN;
      drain_cnt_q     <= '0;
      settle_cnt_q    <= '0;
      res_cnt_q       <= '0;
      quiesce_q       <= 1'b0;
      sack_q          <= 1'b0;
      suspended_q     <= 1'b0;
      drain_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (sreq_s) begin
            state_q         <= S_DRAIN;
            drain_cnt_q     <= '0;
            drain_timeout_q <= 1'b0;
            quiesce_q       <= 1'b1;
          end
        end

        S_DRAIN: begin
          drain_cnt_q <= sat_inc(drain_cnt_q);
          if (!sreq_s) begin
            state_q   <= S_RUN;
            quiesce_q <= 1'b0;
          end else if (!bus.busy) begin
            state_q      <= S_SETTLE;
            settle_cnt_q <= '0;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_q         <= S_ACK;
            sack_q          <= 1'b1;
            suspended_q     <= 1'b1;
            drain_timeout_q <= 1'b1;
          end
        end

        S_SETTLE: begin
          drain_cnt_q  <= sat_inc(drain_cnt_q);
          settle_cnt_q <= sat_inc(settle_cnt_q);
          if (!sreq_s) begin
            state_q   <= S_RUN;
            quiesce_q <= 1'b0;
          end else if (bus.busy) begin
            // Return to DRAIN without clearing drain_cnt so the timeout still bounds the total.
            state_q <= S_DRAIN;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            state_q     <= S_ACK;
            sack_q      <= 1'b1;
            suspended_q <= 1'b1;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_q         <= S_ACK;
            sack_q          <= 1'b1;
            suspended_q     <= 1'b1;
            drain_timeout_q <= 1'b1;
          end
        end

        S_ACK: begin
          if (!sreq_s) begin
            state_q     <= S_RESUME;
            res_cnt_q   <= '0;
            sack_q      <= 1'b0;
            suspended_q <= 1'b0;
          end
        end

        S_RESUME: begin
          res_cnt_q <= sat_inc(res_cnt_q);
          if (res_cnt_q == RESUME_LAST) begin
            state_q   <= S_RUN;
            quiesce_q <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_RUN;
          quiesce_q   <= 1'b0;
          sack_q      <= 1'b0;
          suspended_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.quiesce       = quiesce_q;
  assign bus.sack          = sack_q;
  assign bus.suspended     = suspended_q;
  assign bus.drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_suspend_ack_ctrl.sv
// Directed bench for suspend_ack_ctrl: default instance plus a short-timeout instance.
// Output vectors are compared as {quiesce, sack, suspended, drain_timeout}.
module tb_suspend_ack_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [3:0] obs;

  suspend_ack_if a_if ();
  suspend_ack_if b_if ();

  suspend_ack_ctrl #(
    .CNT_WIDTH(16), .DRAIN_TIMEOUT(1024), .SETTLE_CYCLES(4), .RESUME_CYCLES(8)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(a_if.slave)
  );

  suspend_ack_ctrl #(
    .CNT_WIDTH(16), .DRAIN_TIMEOUT(16), .SETTLE_CYCLES(4), .RESUME_CYCLES(8)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.sreq = 1'b1; a_if.busy = 1'b0;
    b_if.sreq = 1'b0; b_if.busy = 1'b0;
    tick(4);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_a got=%b exp=%b", obs, 4'b0000); end
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_b got=%b exp=%b", obs, 4'b0000); end
    a_if.sreq = 1'b0;
    rst = 1'b0;
    tick(3);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_idle got=%b exp=%b", obs, 4'b0000); end
  endtask

  task automatic test_nominal();
    a_if.busy = 1'b0;
    a_if.sreq = 1'b1;
    tick(2);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL nom_e1 got=%b exp=%b", obs, 4'b0000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL nom_e2 got=%b exp=%b", obs, 4'b1000); end
    tick(4);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL nom_e6 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL nom_e7 got=%b exp=%b", obs, 4'b1110); end
    a_if.busy = 1'b1;  // busy is ignored while acknowledged
    tick(3);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL nom_ack_hold got=%b exp=%b", obs, 4'b1110); end
    a_if.busy = 1'b0;
    a_if.sreq = 1'b0;
    tick(2);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL nom_f1 got=%b exp=%b", obs, 4'b1110); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL nom_f2 got=%b exp=%b", obs, 4'b1000); end
    tick(7);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL nom_f9 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL nom_f10 got=%b exp=%b", obs, 4'b0000); end
  endtask

  task automatic test_drain();
    a_if.busy = 1'b1;
    a_if.sreq = 1'b1;
    tick(3);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL drain_enter got=%b exp=%b", obs, 4'b1000); end
    tick(20);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL drain_busy got=%b exp=%b", obs, 4'b1000); end
    a_if.busy = 1'b0;
    tick(4);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL drain_settle4 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL drain_ack got=%b exp=%b", obs, 4'b1110); end
    a_if.sreq = 1'b0;
    tick(11);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL drain_run got=%b exp=%b", obs, 4'b0000); end
  endtask

  task automatic test_timeout();
    b_if.busy = 1'b1;
    b_if.sreq = 1'b1;
    tick(3);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL to_enter got=%b exp=%b", obs, 4'b1000); end
    tick(15);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL to_edge15 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b1111) begin errors++; $display("FAIL to_edge16 got=%b exp=%b", obs, 4'b1111); end
    b_if.sreq = 1'b0;
    tick(3);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b1001) begin errors++; $display("FAIL to_resume got=%b exp=%b", obs, 4'b1001); end
    tick(8);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b0001) begin errors++; $display("FAIL to_sticky got=%b exp=%b", obs, 4'b0001); end
    b_if.busy = 1'b0;
    b_if.sreq = 1'b1;
    tick(3);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL to_clear got=%b exp=%b", obs, 4'b1000); end
    tick(5);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL to_normal_ack got=%b exp=%b", obs, 4'b1110); end
    b_if.sreq = 1'b0;
    tick(11);
    obs = {b_if.quiesce, b_if.sack, b_if.suspended, b_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL to_run got=%b exp=%b", obs, 4'b0000); end
  endtask

  task automatic test_abort();
    a_if.busy = 1'b0;
    a_if.sreq = 1'b1;
    tick(4);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL abort_settle got=%b exp=%b", obs, 4'b1000); end
    a_if.sreq = 1'b0;
    tick(2);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL abort_f1 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL abort_f2 got=%b exp=%b", obs, 4'b0000); end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (a_if.sack !== 1'b0) begin errors++; $display("FAIL abort_nosack got=%b exp=0", a_if.sack); end
    end
  endtask

  task automatic test_busy_glitch();
    a_if.busy = 1'b0;
    a_if.sreq = 1'b1;
    tick(4);
    a_if.busy = 1'b1;
    tick(1);
    a_if.busy = 1'b0;
    tick(4);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL glitch_e8 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL glitch_e9 got=%b exp=%b", obs, 4'b1110); end
    a_if.sreq = 1'b0;
    tick(11);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL glitch_run got=%b exp=%b", obs, 4'b0000); end
  endtask

  task automatic test_back_to_back();
    a_if.busy = 1'b0;
    a_if.sreq = 1'b1;
    tick(8);
    a_if.sreq = 1'b0;
    tick(4);
    a_if.sreq = 1'b1;  // re-request during RESUME must not shorten the guard
    tick(6);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL b2b_f9 got=%b exp=%b", obs, 4'b1000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL b2b_run got=%b exp=%b", obs, 4'b0000); end
    tick(1);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL b2b_drain got=%b exp=%b", obs, 4'b1000); end
    tick(5);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL b2b_ack got=%b exp=%b", obs, 4'b1110); end
    a_if.sreq = 1'b0;
    tick(11);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL b2b_end got=%b exp=%b", obs, 4'b0000); end
  endtask

  task automatic test_reset_during_ack();
    a_if.busy = 1'b0;
    a_if.sreq = 1'b1;
    tick(8);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL rst_ack_pre got=%b exp=%b", obs, 4'b1110); end
    #1;
    rst = 1'b1;
    #1;
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL rst_ack_async got=%b exp=%b", obs, 4'b0000); end
    a_if.sreq = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    a_if.sreq = 1'b1;
    tick(3);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1000) begin errors++; $display("FAIL rst_rereq_e2 got=%b exp=%b", obs, 4'b1000); end
    tick(5);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b1110) begin errors++; $display("FAIL rst_rereq_e7 got=%b exp=%b", obs, 4'b1110); end
    a_if.sreq = 1'b0;
    tick(11);
    obs = {a_if.quiesce, a_if.sack, a_if.suspended, a_if.drain_timeout};
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL rst_rereq_end got=%b exp=%b", obs, 4'b0000); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_if.sreq = 1'b0; a_if.busy = 1'b0;
    b_if.sreq = 1'b0; b_if.busy = 1'b0;
    test_reset();
    test_nominal();
    test_drain();
    test_timeout();
    test_abort();
    test_busy_glitch();
    test_back_to_back();
    test_reset_during_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
